seq_detect_prog: RTL and testbench

//  Runtime-programmable serial pattern detector for bit streams up to MAX_LEN bits long.
//  - Supports overlapping and non-overlapping match modes.
//  - Gates input bits with a qualifier; only qualified bits are examined.
//  - Outputs a registered one-cycle match pulse and a saturating match counter.
//  - Resets to the default pattern 1011, overlapping.

---
 rtl/seq_detect_prog_if.sv | 26 ++
 rtl/seq_detect_prog.sv | 100 ++++++++++
 tb/tb_seq_detect_prog.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detect_prog_if.sv
// Bus bundle for the programmable serial pattern detector: stream, config, counter control and results.
interface seq_detect_prog_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    parameter int unsigned CNT_W   = 16
);
    logic               din;
    logic               din_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        input  match, match_cnt
    );

    modport slave (
        input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
        output match, match_cnt
    );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial pattern detector with overlap/restart modes,
// registered one-cycle match pulse and saturating match counter.
module seq_detect_prog #(
    parameter int unsigned        MAX_LEN     = 8,
    parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
    parameter int unsigned        CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1011),
    parameter int unsigned        DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_prog_if.slave   bus
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    // Only the MAX_LEN-1 older bits are stored; the incoming bit completes the window.
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   cfg_len_clamp;
    logic               sample;
    logic               hit;

    // Compare mask covering the low len bits of the window.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len_q));
        end
    end

    always_comb begin
        sample        = bus.din_valid && !bus.cfg_load;
        hist_shift    = {hist_q, bus.din};
        fill_inc      = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);
        cfg_len_clamp = (bus.cfg_len > MAX_LEN_L) ? MAX_LEN_L : bus.cfg_len;
        hit           = sample && (len_q != '0) && (fill_inc >= len_q) &&
                        (((hist_shift ^ pattern_q) & mask) == '0);

        pattern_d = pattern_q;
        len_d     = len_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        match_d   = hit;
        cnt_d     = cnt_q;

        // A load wins over a coincident data bit and flushes all history.
        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            len_d     = cfg_len_clamp;
            overlap_d = bus.cfg_overlap;
            hist_d    = '0;
            fill_d    = '0;
        end else if (bus.din_valid) begin
            hist_d = hist_shift[MAX_LEN-2:0];
            fill_d = (hit && !overlap_q) ? '0 : fill_inc;
        end

        if (bus.cnt_clr) begin
            cnt_d = CNT_W'(hit);
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q <= DEF_PATTERN;
            len_q     <= LEN_W'(DEF_LEN);
            overlap_q <= DEF_OVERLAP;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            overlap_q <= overlap_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Randomized and directed bench for seq_detect_prog against a queue-based pattern model.
module tb_seq_detect_prog;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CNT_W2  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W))  bus16 ();
    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W2)) bus2 ();

    assign bus2.din         = bus16.din;
    assign bus2.din_valid   = bus16.din_valid;
    assign bus2.cfg_load    = bus16.cfg_load;
    assign bus2.cfg_pattern = bus16.cfg_pattern;
    assign bus2.cfg_len     = bus16.cfg_len;
    assign bus2.cfg_overlap = bus16.cfg_overlap;
    assign bus2.cnt_clr     = bus16.cnt_clr;

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W))  dut16 (
        .clk(clk), .rst(rst), .bus(bus16.slave));
    seq_detect_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave));

    int checks = 0;
    int errors = 0;

    // Model: queue of bits that may still contribute to a match.
    bit       m_hist[$];
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ov;
    bit       m_match;
    int       m_cnt16;
    int       m_cnt2;
    bit       started = 1'b0;

    always @(posedge clk) begin : model
        bit hit;
        hit = 1'b0;
        if (!rst) begin
            m_hist.delete();
            m_pat   = 8'b0000_1011;
            m_len   = 4;
            m_ov    = 1'b1;
            m_match = 1'b0;
            m_cnt16 = 0;
            m_cnt2  = 0;
            started = 1'b1;
        end else begin
            if (bus16.cfg_load) begin
                m_pat = bus16.cfg_pattern;
                m_len = (int'(bus16.cfg_len) > MAX_LEN) ? MAX_LEN : int'(bus16.cfg_len);
                m_ov  = bus16.cfg_overlap;
                m_hist.delete();
            end else if (bus16.din_valid) begin
                m_hist.push_back(bus16.din);
                if (m_hist.size() > MAX_LEN) void'(m_hist.pop_front());
                if (m_len > 0 && m_hist.size() >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_hist[m_hist.size() - 1 - k] != m_pat[k]) hit = 1'b0;
                end
                if (hit && !m_ov) m_hist.delete();
            end
            m_match = hit;
            if (bus16.cnt_clr) begin
                m_cnt16 = hit ? 1 : 0;
                m_cnt2  = hit ? 1 : 0;
            end else if (hit) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("model_match16", 32'(bus16.match),     32'(m_match));
            chk("model_cnt16",   32'(bus16.match_cnt), 32'(m_cnt16));
            chk("model_match2",  32'(bus2.match),      32'(m_match));
            chk("model_cnt2",    32'(bus2.match_cnt),  32'(m_cnt2));
        end
    end

    // One clock of stimulus; returns just after the edge so outputs reflect it.
    task automatic cyc(input bit v, input bit d, input bit ld = 1'b0,
                       input bit clr = 1'b0, input bit r = 1'b1);
        @(negedge clk);
        rst             = r;
        bus16.din_valid = v;
        bus16.din       = d;
        bus16.cfg_load  = ld;
        bus16.cnt_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input bit [7:0] pat, input bit [3:0] len, input bit ov);
        bus16.cfg_pattern = pat;
        bus16.cfg_len     = len;
        bus16.cfg_overlap = ov;
    endtask

    bit s7[7]   = '{1, 0, 1, 1, 0, 1, 1};
    bit e_t1[7] = '{0, 0, 0, 1, 0, 0, 1};
    bit e_t2[7] = '{0, 0, 0, 1, 0, 0, 0};
    bit s6[6]   = '{1, 1, 0, 1, 1, 0};
    bit e_t4[6] = '{0, 0, 1, 0, 0, 1};
    bit s4[4]   = '{1, 0, 1, 1};

    initial begin
        rst               = 1'b0;
        bus16.din         = 1'b0;
        bus16.din_valid   = 1'b0;
        bus16.cfg_load    = 1'b0;
        bus16.cnt_clr     = 1'b0;
        set_cfg(8'h00, 4'd0, 1'b0);

        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rst_match", 32'(bus16.match), 0);
        chk("rst_cnt",   32'(bus16.match_cnt), 0);

        // T1 default overlapping 1011
        for (int i = 0; i < 7; i++) begin
            cyc(1, s7[i]);
            chk($sformatf("t1_match%0d", i), 32'(bus16.match), 32'(e_t1[i]));
        end
        chk("t1_cnt", 32'(bus16.match_cnt), 2);

        // T2 non-overlapping
        set_cfg(8'b1011, 4'd4, 1'b0);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1, s7[i]);
            chk($sformatf("t2_match%0d", i), 32'(bus16.match), 32'(e_t2[i]));
        end
        chk("t2_cnt", 32'(bus16.match_cnt), 1);

        // T3 gaps between valid bits
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1, s4[i]);
            chk($sformatf("t3_bit%0d", i), 32'(bus16.match), (i == 3) ? 1 : 0);
            for (int g = 0; g < 3; g++) begin
                cyc(0, g[0]);
                chk($sformatf("t3_gap%0d_%0d", i, g), 32'(bus16.match), 0);
            end
        end

        // T4 pattern 110 overlapping
        set_cfg(8'b110, 4'd3, 1'b1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(1, s6[i]);
            chk($sformatf("t4_match%0d", i), 32'(bus16.match), 32'(e_t4[i]));
        end

        // T5 saturation on the 2-bit counter, then clear on a match edge
        cyc(0, 0, 1, 1);
        for (int r = 0; r < 5; r++) begin
            cyc(1, 1); cyc(1, 1); cyc(1, 0);
        end
        chk("t5_cnt2_sat", 32'(bus2.match_cnt), 3);
        chk("t5_cnt16",    32'(bus16.match_cnt), 5);
        cyc(1, 1); cyc(1, 1); cyc(1, 0, 0, 1);
        chk("t5_clr_match_cnt2",  32'(bus2.match_cnt), 1);
        chk("t5_clr_match_cnt16", 32'(bus16.match_cnt), 1);

        // T6 reset mid-stream restores default and drops history
        cyc(1, 1); cyc(1, 0); cyc(1, 1);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1);
        chk("t6_no_match", 32'(bus16.match), 0);
        cyc(1, 0); cyc(1, 1); cyc(1, 1);
        chk("t6_default_match", 32'(bus16.match), 1);

        // Length zero disables detection
        set_cfg(8'hFF, 4'd0, 1'b1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 1'($urandom_range(0, 1)));
            chk($sformatf("len0_match%0d", i), 32'(bus16.match), 0);
        end
        chk("len0_cnt", 32'(bus16.match_cnt), 0);

        // Load coincident with the final pattern bit
        set_cfg(8'b1011, 4'd4, 1'b1);
        cyc(0, 0, 1);
        cyc(1, 1); cyc(1, 0); cyc(1, 1);
        cyc(1, 1, 1);
        chk("load_drop_match", 32'(bus16.match), 0);
        for (int i = 0; i < 4; i++) cyc(1, s4[i]);
        chk("load_fresh_match", 32'(bus16.match), 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit [3:0] l;
            r = int'($urandom_range(0, 99));
            if (r >= 1 && r <= 3) begin
                l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
                set_cfg(8'($urandom()), l, 1'($urandom_range(0, 1)));
            end
            cyc($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                (r >= 1 && r <= 3), (r >= 4 && r <= 6), (r != 0));
        end
        cyc(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
